// File: rtl/div_ratio_detector.sv
// Measures period and high time of a clk-synchronous divided waveform,
// tracks lock on repeated identical measurements and flags a stalled input.
module div_ratio_detector #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    output logic             meas_valid,
    output logic             duty50,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [3:0]       LOCK_Q = 4'(LOCK_N);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [3:0]       match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic             meas_valid_q, meas_valid_d;
    logic             duty50_q, duty50_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             rise;
    logic [3:0]       match_new;

    assign rise = sig_in & ~prev_q;

    always_comb begin
        state_d      = state_q;
        prev_d       = sig_in;
        match_d      = match_q;
        period_d     = period_q;
        high_len_d   = high_len_q;
        meas_valid_d = 1'b0;
        duty50_d     = duty50_q;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        match_new    = 4'd1;

        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            cnt_d  = (cnt_q == MAX) ? MAX : cnt_q + CNT_W'(1);
            hcnt_d = (sig_in && hcnt_q != MAX) ? hcnt_q + CNT_W'(1) : hcnt_q;
        end

        case (state_q)
            IDLE: begin
                if (rise) state_d = ARMED;
            end
            default: begin
                if (rise) begin
                    // Run length of identical measurements, compared against the held outputs
                    if (match_q == 4'd0 || cnt_q != period_q || hcnt_q != high_len_q)
                        match_new = 4'd1;
                    else
                        match_new = (match_q >= LOCK_Q) ? LOCK_Q : match_q + 4'd1;
                    match_d      = match_new;
                    period_d     = cnt_q;
                    high_len_d   = hcnt_q;
                    duty50_d     = ({hcnt_q, 1'b0} == {1'b0, cnt_q});
                    meas_valid_d = 1'b1;
                    timeout_d    = 1'b0;
                    locked_d     = (match_new >= LOCK_Q);
                    state_d      = (match_new >= LOCK_Q) ? LOCKED : ARMED;
                end else if (cnt_q == MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = 4'd0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            match_q      <= '0;
            period_q     <= '0;
            high_len_q   <= '0;
            meas_valid_q <= 1'b0;
            duty50_q     <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            match_q      <= match_d;
            period_q     <= period_d;
            high_len_q   <= high_len_d;
            meas_valid_q <= meas_valid_d;
            duty50_q     <= duty50_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_len   = high_len_q;
    assign meas_valid = meas_valid_q;
    assign duty50     = duty50_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/div_ratio_detector.md
Name: div_ratio_detector

Overview:
- Receive-side companion to the team's clock divider.
- Samples a divided waveform that is synchronous to clk and measures its period and high time in clk cycles.
- Flags when the waveform has been stable long enough to trust ("locked"), and flags a stalled input (timeout).
- Used to self-check divider outputs (div2/div4/div6 style) and to identify an unknown division ratio at run time.

Parameters:
- CNT_W, 8, width of the period/high counters; MAX = 2^CNT_W-1 is the longest measurable period.
- LOCK_N, 3, number of consecutive identical measurements (period and high_len) required to assert locked; legal range 1..15.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- sig_in  in  1  divided waveform; synchronous to clk, glitch-free
- period  out  CNT_W  cycles between the last two rising edges of sig_in
- high_len  out  CNT_W  cycles sig_in was high within that period
- meas_valid  out  1  one-cycle pulse; period/high_len updated this cycle
- duty50  out  1  high_len*2 == period for the latest measurement
- locked  out  1  LOCK_N consecutive identical measurements seen
- timeout  out  1  no rising edge within MAX cycles

Behaviour:
- Reset (resetn=0 at posedge):
  - period, high_len, meas_valid, duty50, locked, timeout = 0.
  - prev = 0, cnt = 0, hcnt = 0, match = 0, state = IDLE.
- Edge detect: rise = sig_in & ~prev; prev <= sig_in every cycle.
  - sig_in=1 on the first cycle after reset counts as a rise.
- Counters:
  - On a rise: cnt <= 1 and hcnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at MAX; hcnt <= hcnt+1 when sig_in=1, also saturating.
  - At a rise, cnt equals the period and hcnt equals the high time since the previous rise.
- States: IDLE, ARMED, LOCKED.
  - IDLE:
    - rise -> ARMED; counters load; no measurement.
  - ARMED / LOCKED, on rise:
    - Register period <= cnt, high_len <= hcnt, duty50 <= (hcnt*2 == cnt).
    - meas_valid = 1 for the next cycle only (registered, 1-cycle latency after the rise cycle).
    - timeout <= 0.
  - ARMED / LOCKED, on no rise with cnt == MAX:
    - timeout <= 1, locked <= 0, match <= 0, state -> IDLE.
    - A rise in the same cycle as cnt == MAX is a normal measurement with period = MAX.
- Lock tracking, on each measurement:
  - If match == 0, or (cnt, hcnt) differ from the currently held (period, high_len): match <= 1.
  - Otherwise match <= min(match+1, LOCK_N).
  - locked <= (new match >= LOCK_N); state is LOCKED when locked, else ARMED.
  - A mismatch drops locked in the same cycle meas_valid rises.
  - With LOCK_N=1, the first measurement locks.
- Held outputs:
  - period, high_len and duty50 hold between measurements.
  - They are not cleared by timeout.
  - timeout holds until the next meas_valid or reset.
- Minimum period is 2, since a rise needs a low cycle in between.
  - A constant-high or constant-low input ends in timeout.
- Reset mid-measurement: all state cleared next cycle; the first rise after reset only re-arms.

Test Plan:
- Div-by-2 (sig_in 1,0,1,0...), defaults -> meas_valid every 2 cycles, period=2, high_len=1, duty50=1; locked asserts on the 3rd meas_valid.
- Div-by-6 with high 3 of 6 cycles -> period=6, high_len=3, duty50=1; then switch to div-by-4 (high 2 of 4) -> first period=4 measurement drops locked, which re-asserts 2 measurements later.
- Div-by-5 with high 1 of 5 -> period=5, high_len=1, duty50=0; locked after 3 measurements.
- Hold sig_in=0 after lock (CNT_W=8) -> timeout=1 and locked=0 once cnt hits 255 with no rise; the next two rises clear timeout and give one measurement.
- Single period of exactly 255 -> measured period=255, no timeout.
- Drive resetn=0 for one cycle mid-period while locked -> all outputs 0 next cycle; the first post-reset rise produces no meas_valid.
